// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit:
// operation codes, FSM encoding, iteration count and the sign-correction helper.
package mips_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Two's-complement negation used for the product, quotient and remainder alike.
    function automatic logic [2*MD_XLEN-1:0] md_negate(input logic [2*MD_XLEN-1:0] x);
        return ~x + {{(2*MD_XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/addsub_33.sv
// 33-bit adder/subtractor shared by the shift-add multiply and restoring divide steps.
// With sub_i=1 it computes a_i - b_i; cout_o=1 then means "no borrow" (result non-negative).
module addsub_33 (
    input  logic [32:0] a_i,
    input  logic [32:0] b_i,
    input  logic        sub_i,
    output logic [32:0] sum_o,
    output logic        cout_o
);

    logic [33:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i ^ {33{sub_i}}} + {33'b0, sub_i};
    assign sum_o  = full[32:0];
    assign cout_o = full[33];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO: accept, 32 add/sub iterations,
// one sign-fix cycle. Handshake: start is taken only in IDLE (busy=0); done pulses with HI/LO valid.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int W2 = 2 * WIDTH;

    md_state_e        state_q;
    logic [4:0]       count_q;
    logic [1:0]       op_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic             dbz_q;
    logic [WIDTH-1:0] dbz_hi_q;
    logic [WIDTH-1:0] mcand_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_out_q;

    logic             signed_op;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             is_div;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_sum;
    logic             add_cout;
    logic [W2-1:0]    acc_d;
    logic [WIDTH-1:0] res_hi_d;
    logic [WIDTH-1:0] res_lo_d;

    // Operand magnitudes at accept; unsigned ops pass operands through untouched.
    always_comb begin
        signed_op = ~op[0];
        rs_mag    = (signed_op && rs[WIDTH-1]) ? -rs : rs;
        rt_mag    = (signed_op && rt[WIDTH-1]) ? -rt : rt;
    end

    assign is_div = op_q[1];
    // Multiply adds into the upper half; divide subtracts from the left-shifted remainder.
    assign add_a  = is_div ? acc_q[W2-1:WIDTH-1] : {1'b0, acc_q[W2-1:WIDTH]};
    assign add_b  = {1'b0, mcand_q};

    addsub_33 u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (is_div),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        acc_d = acc_q;
        if (is_div) begin
            if (add_cout) begin
                acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[W2-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[W2-1:1]};
            end
        end
    end

    // Sign correction; the divide-by-zero result overrides the algorithm's output.
    always_comb begin
        res_hi_d = acc_q[W2-1:WIDTH];
        res_lo_d = acc_q[WIDTH-1:0];
        if (!is_div) begin
            if (neg_quot_q && !op_q[0]) begin
                {res_hi_d, res_lo_d} = md_negate(acc_q);
            end
        end else if (dbz_q) begin
            res_hi_d = dbz_hi_q;
            res_lo_d = '1;
        end else begin
            if (neg_quot_q) begin
                res_lo_d = WIDTH'(md_negate({{WIDTH{1'b0}}, acc_q[WIDTH-1:0]}));
            end
            if (neg_rem_q) begin
                res_hi_d = WIDTH'(md_negate({{WIDTH{1'b0}}, acc_q[W2-1:WIDTH]}));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_hi_q   <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_out_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        neg_quot_q <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        neg_rem_q  <= (op == MD_DIV) & rs[WIDTH-1];
                        dbz_q      <= op[1] & (rt == '0);
                        dbz_hi_q   <= rs;
                        if (op[1]) begin
                            mcand_q <= rt_mag;
                            acc_q   <= {{WIDTH{1'b0}}, rs_mag};
                        end else begin
                            mcand_q <= rs_mag;
                            acc_q   <= {{WIDTH{1'b0}}, rt_mag};
                        end
                        count_q <= '0;
                        state_q <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    if (count_q == 5'(MD_ITER - 1)) begin
                        state_q <= MD_FIX;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end
                MD_FIX: begin
                    hi_q      <= res_hi_d;
                    lo_q      <= res_lo_d;
                    done_q    <= 1'b1;
                    dbz_out_q <= dbz_q;
                    state_q   <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != MD_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases from the block's corner list
// plus randomized operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Expected results: {div_by_zero, hi, lo}
    logic [64:0] exp_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        q  = '0;
        r  = '0;
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
            end
        endcase
        return {1'b0, r, q};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        exp_q.push_back(ref_model(o, a, b));
    endtask

    // Consumes the accept edge, waits (bounded) for done and scores the result.
    // poke_at > 0 drives a spurious start with fresh operands at that cycle of the operation.
    task automatic wait_done(input string tag, input int poke_at);
        int          lat;
        logic        busy_ok;
        logic [64:0] e;
        busy_ok = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == poke_at) begin
                op    = 2'($urandom_range(0, 3));
                rs    = $urandom;
                rt    = $urandom;
                start = 1'b1;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_during"}, {63'b0, busy_ok}, 64'd1);
        check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'b0, hi}, {32'b0, e[63:32]});
            check({tag, "_lo"}, {32'b0, lo}, {32'b0, e[31:0]});
            check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e[64]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        saw_done;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        rs    = '0;
        rt    = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);

        // Directed corners, each started on the previous op's done cycle.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 0);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 0);
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu", 0);
        issue(2'b11, 32'h64, 32'd0);
        wait_done("divu_zero", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("hi_hold", {32'b0, hi}, 64'd0);
        check("lo_hold", {32'b0, lo}, 64'h8000_0000);

        // Start while busy must be ignored.
        issue(2'b01, 32'd12345, 32'd678);
        wait_done("ignore_busy_start", 5);
        tick();

        // Reset in the middle of an operation discards it.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_hi", {32'b0, hi}, 64'd0);
        check("midrst_lo", {32'b0, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("midrst_no_done", {63'b0, saw_done}, 64'd0);
        issue(2'b01, 32'd3, 32'd4);
        wait_done("multu_after_rst", 0);

        // Randomized operations, mixing zero divisors, small and full-range operands.
        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) b = -32'($urandom_range(1, 15));
            else if (sel == 3) a = 32'($urandom_range(0, 100));
            issue(o, a, b);
            wait_done($sformatf("rand%0d_op%0d", i, o), ($urandom_range(0, 3) == 0) ? 7 : 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
